// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the MEM/WB pipeline register and the writeback path.
//   Data words use big-endian bit numbering [0:DATA_W-1]: bit 0 is the MSB and
//   byte 0 occupies bits [0:7].
//   Contents: DSize encodings, the MEM/WB bundle (mem_wb_t), REG_ZERO.
//   Optional feature macro: MISALIGN_CHECK_EN adds the registered misalign flag
//   to mem_wb_t.
package pipeline_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_REG_ADDR_W = 5;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_WORD = 2'b10;  // 2'b11 is also treated as word

    localparam logic [PIPE_REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [0:PIPE_DATA_W-1]     nextPC;
        logic [PIPE_REG_ADDR_W-1:0] destReg;
        logic [0:PIPE_DATA_W-1]     aluResult;
        logic [0:PIPE_DATA_W-1]     dataOut;
        logic                       PCtoReg;
        logic                       RegWrite;
        logic                       MemToReg;
        logic                       loadSign;
        logic [1:0]                 DSize;
`ifdef MISALIGN_CHECK_EN
        logic                       misalign;
`endif
    } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// load_align
//   Purely combinational load alignment and extension.
//   Ports:
//     rawWord   [0:DATA_W-1]  word read from data memory (big-endian bit order)
//     offset    [0:1]         byte offset within the word (address bits 30:31)
//     size      [1:0]         DSIZE_BYTE / DSIZE_HALF / word (10 or 11)
//     signExt                 1 = sign-extend sub-word values
//     loadValue [0:DATA_W-1]  aligned, extended result (sub-word in the LSBs)
module load_align
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic [0:DATA_W-1] rawWord,
    input  logic [0:1]        offset,
    input  logic [1:0]        size,
    input  logic              signExt,
    output logic [0:DATA_W-1] loadValue
);

    logic [0:7]  selByte;
    logic [0:15] selHalf;

    // offset[0] is the more significant offset bit; halfword selection ignores
    // offset[1], so an odd address reads the half that contains it.
    assign selByte = rawWord[{offset, 3'b000} +: 8];
    assign selHalf = rawWord[{offset[0], 4'b0000} +: 16];

    always_comb begin
        loadValue = rawWord;
        case (size)
            DSIZE_BYTE: loadValue = {{(DATA_W-8){signExt & selByte[0]}}, selByte};
            DSIZE_HALF: loadValue = {{(DATA_W-16){signExt & selHalf[0]}}, selHalf};
            default:    loadValue = rawWord;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   MEM/WB pipeline register plus writeback datapath. Captures memory-stage
//   outputs, aligns/extends load data, selects the register-file write value
//   and keeps the previously retired write for decode-stage forwarding.
//   Ports:
//     clk, reset (sync, active high), stall (hold), flush (insert bubble)
//     *_in           memory-stage outputs captured into MEM/WB
//     regWr*         register-file write port, driven from MEM/WB only
//     prevWr*        previous retired write, for forwarding
//     misalign       (only with MISALIGN_CHECK_EN) misaligned load flag
//   Optional feature macro: MISALIGN_CHECK_EN
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [0:DATA_W-1]     nextPC_in,
    input  logic [REG_ADDR_W-1:0] destReg_in,
    input  logic [0:DATA_W-1]     aluResult_in,
    input  logic [0:DATA_W-1]     dataOut_in,
    input  logic                  PCtoReg_in,
    input  logic                  RegWrite_in,
    input  logic                  MemToReg_in,
    input  logic                  loadSign_in,
    input  logic [1:0]            DSize_in,
    output logic [0:DATA_W-1]     regWrData,
    output logic [REG_ADDR_W-1:0] regWrAddr,
    output logic                  regWrEn,
    output logic [0:DATA_W-1]     prevWrData,
    output logic [REG_ADDR_W-1:0] prevWrAddr,
    output logic                  prevWrValid
`ifdef MISALIGN_CHECK_EN
   ,output logic                  misalign
`endif
);

    mem_wb_t           memWb;
    mem_wb_t           memWbNext;
    logic [0:DATA_W-1] loadData;

    always_comb begin
        memWbNext           = '0;
        memWbNext.nextPC    = nextPC_in;
        memWbNext.destReg   = destReg_in;
        memWbNext.aluResult = aluResult_in;
        memWbNext.dataOut   = dataOut_in;
        memWbNext.PCtoReg   = PCtoReg_in;
        memWbNext.RegWrite  = RegWrite_in;
        memWbNext.MemToReg  = MemToReg_in;
        memWbNext.loadSign  = loadSign_in;
        memWbNext.DSize     = DSize_in;
`ifdef MISALIGN_CHECK_EN
        // Halfword is flagged on address bit 31 (the odd byte); words need
        // both offset bits clear.
        memWbNext.misalign  = MemToReg_in &&
            ((DSize_in == DSIZE_HALF && aluResult_in[DATA_W-1]) ||
             (DSize_in[1] && aluResult_in[DATA_W-2:DATA_W-1] != 2'b00));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memWb       <= '0;
            prevWrData  <= '0;
            prevWrAddr  <= '0;
            prevWrValid <= 1'b0;
        end else begin
            if (flush)
                memWb <= '0;
            else if (!stall)
                memWb <= memWbNext;

            // prev* follows the retiring write even on a flush; only a stall freezes it.
            if (!stall) begin
                prevWrData  <= regWrData;
                prevWrAddr  <= regWrAddr;
                prevWrValid <= regWrEn;
            end
        end
    end

    load_align #(.DATA_W(DATA_W)) uLoadAlign (
        .rawWord   (memWb.dataOut),
        .offset    (memWb.aluResult[DATA_W-2:DATA_W-1]),
        .size      (memWb.DSize),
        .signExt   (memWb.loadSign),
        .loadValue (loadData)
    );

    always_comb begin
        if (memWb.PCtoReg)
            regWrData = memWb.nextPC;
        else if (memWb.MemToReg)
            regWrData = loadData;
        else
            regWrData = memWb.aluResult;
    end

    assign regWrAddr = memWb.destReg;

`ifdef MISALIGN_CHECK_EN
    assign misalign = memWb.misalign;
    assign regWrEn  = memWb.RegWrite && (memWb.destReg != REG_ZERO) && !memWb.misalign;
`else
    assign regWrEn  = memWb.RegWrite && (memWb.destReg != REG_ZERO);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        reset, stall, flush;
    logic [0:31] nextPC_in, aluResult_in, dataOut_in;
    logic [4:0]  destReg_in;
    logic        PCtoReg_in, RegWrite_in, MemToReg_in, loadSign_in;
    logic [1:0]  DSize_in;
    logic [0:31] regWrData, prevWrData;
    logic [4:0]  regWrAddr, prevWrAddr;
    logic        regWrEn, prevWrValid;
`ifdef MISALIGN_CHECK_EN
    logic        misalign;
`endif

    writeback_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .nextPC_in(nextPC_in), .destReg_in(destReg_in),
        .aluResult_in(aluResult_in), .dataOut_in(dataOut_in),
        .PCtoReg_in(PCtoReg_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .loadSign_in(loadSign_in),
        .DSize_in(DSize_in),
        .regWrData(regWrData), .regWrAddr(regWrAddr), .regWrEn(regWrEn),
        .prevWrData(prevWrData), .prevWrAddr(prevWrAddr), .prevWrValid(prevWrValid)
`ifdef MISALIGN_CHECK_EN
       ,.misalign(misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one captured instruction (numeric, little-endian view).
    typedef struct {
        logic [31:0] pc, alu, data;
        logic [4:0]  dest;
        logic        link, rw, m2r, sgn;
        logic [1:0]  sz;
    } txn_t;

    txn_t        cap;
    logic [31:0] pData;
    logic [4:0]  pAddr;
    logic        pValid;

    function automatic txn_t zeroTxn();
        txn_t t;
        t.pc = 0; t.alu = 0; t.data = 0; t.dest = 0;
        t.link = 0; t.rw = 0; t.m2r = 0; t.sgn = 0; t.sz = 0;
        return t;
    endfunction

    function automatic logic [31:0] refLoad(txn_t t);
        longint unsigned v;
        int bits;
        int off;
        off = int'(t.alu[1:0]);
        if (t.sz == 2'b00) begin
            v = (longint'(t.data) >> (8 * (3 - off))) & 64'hFF;
            bits = 8;
        end else if (t.sz == 2'b01) begin
            v = (off >= 2) ? (longint'(t.data) & 64'hFFFF) : (longint'(t.data) >> 16);
            bits = 16;
        end else begin
            return t.data;
        end
        if (t.sgn && v >= (64'd1 << (bits - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] refData(txn_t t);
        if (t.link) return t.pc;
        if (t.m2r)  return refLoad(t);
        return t.alu;
    endfunction

    function automatic logic refMis(txn_t t);
        return t.m2r && ((t.sz == 2'b01 && t.alu[0]) || (t.sz[1] && t.alu[1:0] != 2'b00));
    endfunction

    function automatic logic refEn(txn_t t);
`ifdef MISALIGN_CHECK_EN
        return t.rw && t.dest != 5'd0 && !refMis(t);
`else
        return t.rw && t.dest != 5'd0;
`endif
    endfunction

    task automatic checkAll();
        chk("wrData",    regWrData,           refData(cap));
        chk("wrAddr",    32'(regWrAddr),      32'(cap.dest));
        chk("wrEn",      32'(regWrEn),        32'(refEn(cap)));
        chk("prevData",  prevWrData,          pData);
        chk("prevAddr",  32'(prevWrAddr),     32'(pAddr));
        chk("prevValid", 32'(prevWrValid),    32'(pValid));
`ifdef MISALIGN_CHECK_EN
        chk("misalign",  32'(misalign),       32'(refMis(cap)));
`endif
    endtask

    // One clock: update the model with the inputs seen at the edge, then check.
    task automatic step();
        txn_t        inTx;
        logic [31:0] oD;
        logic [4:0]  oA;
        logic        oE;
        oD = refData(cap);
        oA = cap.dest;
        oE = refEn(cap);
        @(posedge clk);
        inTx.pc = nextPC_in; inTx.alu = aluResult_in; inTx.data = dataOut_in;
        inTx.dest = destReg_in; inTx.link = PCtoReg_in; inTx.rw = RegWrite_in;
        inTx.m2r = MemToReg_in; inTx.sgn = loadSign_in; inTx.sz = DSize_in;
        if (reset) begin
            cap = zeroTxn(); pData = 0; pAddr = 0; pValid = 0;
        end else begin
            if (!stall) begin
                pData = oD; pAddr = oA; pValid = oE;
            end
            if (flush)       cap = zeroTxn();
            else if (!stall) cap = inTx;
        end
        #2;
        checkAll();
    endtask

    task automatic setIn(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] data,
                         input logic [4:0] dest, input logic link, input logic rw,
                         input logic m2r, input logic sgn, input logic [1:0] sz);
        nextPC_in = pc; aluResult_in = alu; dataOut_in = data; destReg_in = dest;
        PCtoReg_in = link; RegWrite_in = rw; MemToReg_in = m2r; loadSign_in = sgn; DSize_in = sz;
    endtask

    initial begin
        cap = zeroTxn(); pData = 0; pAddr = 0; pValid = 0;
        reset = 1; stall = 0; flush = 0;
        setIn(32'h0, 32'h0, 32'h0, 5'd5, 0, 1, 0, 0, 2'b10);

        // Reset held two cycles with a write request present
        step(); step();
        chk("rst_en",   32'(regWrEn), 0);
        chk("rst_data", regWrData, 0);
        chk("rst_prev", 32'(prevWrValid), 0);
        reset = 0;

        // ALU writeback
        setIn(32'h0, 32'h00001234, 32'h0, 5'd3, 0, 1, 0, 0, 2'b10);
        step();
        chk("alu_addr", 32'(regWrAddr), 3);
        chk("alu_data", regWrData, 32'h00001234);
        chk("alu_en",   32'(regWrEn), 1);

        // Load extension
        setIn(32'h0, 32'h00000001, 32'h80FF7F01, 5'd4, 0, 1, 1, 1, 2'b00);
        step();
        chk("ldb_sign", regWrData, 32'hFFFFFFFF);
        loadSign_in = 0;
        step();
        chk("ldb_zero", regWrData, 32'h000000FF);
        aluResult_in = 32'h0; DSize_in = 2'b01; loadSign_in = 1;
        step();
        chk("ldh_sign", regWrData, 32'hFFFF80FF);

        // Link write, then r0 suppression
        setIn(32'h00000408, 32'h0, 32'h0, 5'd31, 1, 1, 0, 0, 2'b10);
        step();
        chk("link_data", regWrData, 32'h00000408);
        setIn(32'h0, 32'h00000077, 32'h0, 5'd0, 0, 1, 0, 0, 2'b10);
        step();
        chk("r0_en", 32'(regWrEn), 0);

        // Stall holds everything for three cycles
        setIn(32'h0, 32'h00000055, 32'h0, 5'd7, 0, 1, 0, 0, 2'b10);
        step();
        stall = 1;
        setIn(32'h0, 32'h000000AA, 32'h0, 5'd9, 0, 1, 0, 0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", regWrData, 32'h00000055);
            chk("stall_en",   32'(regWrEn), 1);
            chk("stall_prev", 32'(prevWrAddr), 0);
        end

        // Stall and flush together: flush wins
        flush = 1;
        step();
        chk("sf_en", 32'(regWrEn), 0);
        stall = 0; flush = 0;
        step();
        chk("rel_data", regWrData, 32'h000000AA);
        step();
        chk("rel_prev", prevWrData, 32'h000000AA);
        chk("rel_prevA", 32'(prevWrAddr), 9);

`ifdef MISALIGN_CHECK_EN
        setIn(32'h0, 32'h00000102, 32'h12345678, 5'd6, 0, 1, 1, 0, 2'b10);
        step();
        chk("mis_set", 32'(misalign), 1);
        chk("mis_en",  32'(regWrEn), 0);
        aluResult_in = 32'h00000100;
        step();
        chk("mis_clr", 32'(misalign), 0);
        chk("mis_en1", 32'(regWrEn), 1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 99) < 3);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 10);
            setIn($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
MEM/WB pipeline register plus writeback datapath, directly downstream of the memory stage. It captures the memory-stage outputs each cycle and aligns and sign/zero-extends load data by size and address. It selects the register-file write value from nextPC, load data or ALU result, and drives the register-file write port. It also holds the previous retired write so decode can forward from it.

Parameters:
DATA_W, 32, datapath width (big-endian bit order [0:DATA_W-1]; byte 0 = bits [0:7])
REG_ADDR_W, 5, register specifier width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold MEM/WB register contents
flush  input  1  load a bubble into MEM/WB
nextPC_in  input  32  link value from memory stage
destReg_in  input  5  destination register
aluResult_in  input  32  ALU result / effective address
dataOut_in  input  32  raw word read from data memory
PCtoReg_in  input  1  write nextPC (link)
RegWrite_in  input  1  register write enable
MemToReg_in  input  1  write load data
loadSign_in  input  1  1 = sign-extend sub-word loads
DSize_in  input  2  00 byte, 01 halfword, 10/11 word
regWrData  output  32  register-file write data
regWrAddr  output  5  register-file write address
regWrEn  output  1  register-file write strobe
prevWrData  output  32  value of the previous retired write
prevWrAddr  output  5  address of the previous retired write
prevWrValid  output  1  previous write valid

Behaviour:
- Reset (synchronous): all MEM/WB fields cleared; regWrEn=0, regWrData=0, regWrAddr=0; prev* all 0. Reset overrides stall and flush.
- Priority each rising edge: reset > flush > stall > capture.
  - flush: RegWrite field=0 and all other fields 0 (bubble).
  - stall: register holds its value.
  - otherwise: all *_in are captured.
- Latency: inputs appear on regWr* one cycle after capture. regWr* are combinational from the registered fields only; no *_in-to-output combinational path.
- Load alignment uses the registered aluResult bits [30:31] as byte offset b.
  - Byte: the selected byte is dataOut[8b : 8b+7].
  - Halfword: the selected half is dataOut[0:15] when b[0]==0, else dataOut[16:31]; b[1] is ignored for selection.
  - Word: dataOut is used unchanged.
  - Sub-word values are placed in the LSBs, then sign- or zero-extended per loadSign.
- Result select priority: PCtoReg -> nextPC; else MemToReg -> aligned load; else aluResult.
- regWrEn = RegWrite and (regWrAddr != 0). Writes to r0 are always suppressed.
- regWrEn is not gated by stall. A held instruction re-asserts its write each stalled cycle, which is idempotent.
- prev* register: at each rising edge with no reset and no stall, it loads {regWrData, regWrAddr, regWrEn}. When stalled it holds.
- Reset mid-stall: reset wins, and the stall is ignored that cycle.
- Simultaneous stall and flush: flush wins.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: adds output misalign (1 bit, registered with the MEM/WB fields). It is set when MemToReg=1 and either of these holds:
  - halfword with b[1]!=0 (intended check: b[0]!=0; the team fixes the rule as address bit 31 set), or
  - word with b!=0.
  When misalign is set, regWrEn is forced to 0.
- Undefined: no misalign port, no check; misaligned loads use the alignment rules above.

Decomposition:
- Shared package pipeline_pkg holds:
  - DSize encodings (DSIZE_BYTE=2'b00, DSIZE_HALF=2'b01, DSIZE_WORD=2'b10)
  - a MEM/WB bundle typedef (mem_wb_t)
  - the constant REG_ZERO=5'd0
- One natural sub-module: load_align, purely combinational (raw word, offset, size, sign -> extended value). It is reusable by any future store/load unit.

Test Plan:
- Reset: assert reset 2 cycles with RegWrite_in=1 -> regWrEn=0, regWrData=0, prevWrValid=0.
- ALU writeback: aluResult_in=0x00001234, destReg_in=3, RegWrite_in=1 -> next cycle regWrAddr=3, regWrData=0x00001234, regWrEn=1.
- Load extension:
  - dataOut_in=0x80FF7F01, aluResult_in=0x..01, DSize=00, loadSign=1 -> regWrData=0xFFFFFFFF.
  - Same with loadSign=0 -> 0x000000FF.
  - Offset 0, halfword, signed -> 0xFFFF80FF.
- Link and r0: PCtoReg_in=1, nextPC_in=0x00000408, destReg_in=31 -> regWrData=0x00000408. Then destReg_in=0, RegWrite_in=1 -> regWrEn=0.
- Stall/flush:
  - Hold stall 3 cycles -> outputs and prev* unchanged.
  - stall+flush together -> regWrEn=0 next cycle.
  - prevWrAddr/Data track the previous retired write after release.
- MISALIGN_CHECK_EN: word load at aluResult_in=0x00000102 -> misalign=1, regWrEn=0. At 0x00000100 -> misalign=0.
